// File: rtl/vend_pkg.sv
// Shared types and coin encodings for the vending transaction controller.
package vend_pkg;

    typedef enum logic [2:0] {
        IDLE,
        COLLECT,
        VEND,
        CHANGE,
        REFUND
    } state_t;

    localparam logic [1:0] COIN_NONE = 2'b00;
    localparam logic [1:0] COIN_5    = 2'b01;
    localparam logic [1:0] COIN_10   = 2'b10;

    localparam int unsigned COIN_UNIT = 5;

    function automatic logic [3:0] coin_value(input logic [1:0] code);
        case (code)
            COIN_NONE: return 4'd0;
            COIN_5:    return 4'd5;
            COIN_10:   return 4'd10;
            default:   return 4'd0;
        endcase
    endfunction

endpackage

// File: rtl/vend_ctrl_rr_arb2.sv
// Two-requester round-robin arbiter; priority flips to the other port after each accepted grant.
module rr_arb2 (
    input  logic       clk,
    input  logic       rst,
    input  logic [1:0] req_i,
    input  logic       gate_i,
    input  logic       accept_i,
    output logic [1:0] gnt_o
);

    // Port favoured when both request; starts on port 0.
    logic prio_q;

    always_comb begin
        gnt_o = '0;
        if (gate_i) begin
            if (req_i == 2'b11) begin
                gnt_o = prio_q ? 2'b10 : 2'b01;
            end else begin
                gnt_o = req_i;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            prio_q <= 1'b0;
        end else if (accept_i) begin
            prio_q <= gnt_o[0];
        end
    end

endmodule

// File: rtl/vend_ctrl.sv
// Vending transaction controller: coin arbitration, credit, dispense, change/refund, stock.
// Optional collect inactivity timeout enabled by defining VEND_TIMEOUT_EN.
module vend_ctrl #(
    parameter int unsigned PRICE      = 15,
    parameter int unsigned CREDIT_W   = 5,
    parameter int unsigned STOCK_INIT = 8,
    parameter int unsigned STOCK_W    = 4
`ifdef VEND_TIMEOUT_EN
   ,parameter int unsigned TIMEOUT_CYC = 1000
`endif
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                coin0_valid,
    input  logic [1:0]          coin0_val,
    output logic                coin0_ready,
    input  logic                coin1_valid,
    input  logic [1:0]          coin1_val,
    output logic                coin1_ready,
    input  logic                cancel,
    input  logic                restock,
    output logic                vend,
    output logic                change_pulse,
    output logic                busy,
    output logic                sold_out,
    output logic [CREDIT_W-1:0] credit,
    output logic [STOCK_W-1:0]  stock
);
    import vend_pkg::*;

    localparam logic [CREDIT_W-1:0] PRICE_C = CREDIT_W'(PRICE);
    localparam logic [CREDIT_W-1:0] UNIT_C  = CREDIT_W'(COIN_UNIT);
    localparam logic [STOCK_W-1:0]  STOCK_C = STOCK_W'(STOCK_INIT);

    state_t              state_q;
    logic [CREDIT_W-1:0] credit_q;
    logic [STOCK_W-1:0]  stock_q;
    logic                vend_q;
    logic                change_q;

    logic [1:0]          gnt;
    logic                gate;
    logic                xfer;
    logic                tmo_hit;
    logic [1:0]          code_sel;
    logic [CREDIT_W-1:0] credit_sum;
    logic [CREDIT_W-1:0] credit_less;

    assign gate = !rst && (state_q == IDLE || state_q == COLLECT)
                  && (stock_q != '0) && !cancel && !tmo_hit;

    rr_arb2 u_arb (
        .clk      (clk),
        .rst      (rst),
        .req_i    ({coin1_valid, coin0_valid}),
        .gate_i   (gate),
        .accept_i (xfer),
        .gnt_o    (gnt)
    );

    // A grant is only ever issued to a valid port, so any grant is a transfer.
    assign xfer        = |gnt;
    assign code_sel    = gnt[1] ? coin1_val : coin0_val;
    assign credit_sum  = credit_q + CREDIT_W'(coin_value(code_sel));
    assign credit_less = credit_q - UNIT_C;

`ifdef VEND_TIMEOUT_EN
    localparam int unsigned TMO_W = $clog2(TIMEOUT_CYC);
    logic [TMO_W-1:0] tmo_q;

    assign tmo_hit = (state_q == COLLECT) && (tmo_q == TMO_W'(TIMEOUT_CYC - 1));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            tmo_q <= '0;
        end else if (state_q != COLLECT || xfer || tmo_hit) begin
            tmo_q <= '0;
        end else begin
            tmo_q <= tmo_q + TMO_W'(1);
        end
    end
`else
    assign tmo_hit = 1'b0;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= IDLE;
            credit_q <= '0;
            stock_q  <= STOCK_C;
            vend_q   <= 1'b0;
            change_q <= 1'b0;
        end else begin
            vend_q   <= 1'b0;
            change_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (restock) begin
                        stock_q <= STOCK_C;
                    end
                    // A zero-value coin leaves credit at 0, so remain idle.
                    if (xfer) begin
                        credit_q <= credit_sum;
                        if (credit_sum >= PRICE_C) begin
                            state_q <= VEND;
                            vend_q  <= 1'b1;
                        end else if (credit_sum != '0) begin
                            state_q <= COLLECT;
                        end
                    end
                end
                COLLECT: begin
                    if (cancel || tmo_hit) begin
                        state_q  <= REFUND;
                        change_q <= 1'b1;
                    end else if (xfer) begin
                        credit_q <= credit_sum;
                        if (credit_sum >= PRICE_C) begin
                            state_q <= VEND;
                            vend_q  <= 1'b1;
                        end
                    end
                end
                VEND: begin
                    stock_q  <= stock_q - STOCK_W'(1);
                    credit_q <= credit_q - PRICE_C;
                    if (credit_q != PRICE_C) begin
                        state_q  <= CHANGE;
                        change_q <= 1'b1;
                    end else begin
                        state_q <= IDLE;
                    end
                end
                CHANGE, REFUND: begin
                    credit_q <= credit_less;
                    if (credit_less == '0) begin
                        state_q <= IDLE;
                    end else begin
                        change_q <= 1'b1;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign coin0_ready  = gnt[0];
    assign coin1_ready  = gnt[1];
    assign vend         = vend_q;
    assign change_pulse = change_q;
    assign busy         = (state_q == VEND) || (state_q == CHANGE) || (state_q == REFUND);
    assign sold_out     = (stock_q == '0);
    assign credit       = credit_q;
    assign stock        = stock_q;

endmodule

// File: tb/tb_vend_ctrl.sv
// Directed self-checking bench for vend_ctrl (default parameters).
module tb_vend_ctrl;

    logic       clk = 1'b0;
    logic       rst;
    logic       coin0_valid, coin1_valid;
    logic [1:0] coin0_val, coin1_val;
    logic       coin0_ready, coin1_ready;
    logic       cancel, restock;
    logic       vend, change_pulse, busy, sold_out;
    logic [4:0] credit;
    logic [3:0] stock;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    vend_ctrl #(
        .PRICE      (15),
        .CREDIT_W   (5),
        .STOCK_INIT (8),
        .STOCK_W    (4)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .coin0_valid  (coin0_valid),
        .coin0_val    (coin0_val),
        .coin0_ready  (coin0_ready),
        .coin1_valid  (coin1_valid),
        .coin1_val    (coin1_val),
        .coin1_ready  (coin1_ready),
        .cancel       (cancel),
        .restock      (restock),
        .vend         (vend),
        .change_pulse (change_pulse),
        .busy         (busy),
        .sold_out     (sold_out),
        .credit       (credit),
        .stock        (stock)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Present one coin, expect immediate acceptance, hold through one edge.
    task automatic send(input int port, input logic [1:0] code);
        if (port == 0) begin
            coin0_valid = 1'b1;
            coin0_val   = code;
        end else begin
            coin1_valid = 1'b1;
            coin1_val   = code;
        end
        #1;
        check("send_ready", 32'(port == 0 ? coin0_ready : coin1_ready), 32'd1);
        step();
        coin0_valid = 1'b0;
        coin1_valid = 1'b0;
    endtask

    initial begin
        rst = 1'b1;
        coin0_valid = 1'b0; coin0_val = 2'b00;
        coin1_valid = 1'b0; coin1_val = 2'b00;
        cancel = 1'b0; restock = 1'b0;

        coin0_valid = 1'b1; coin0_val = 2'b01;
        #1;
        check("rst_ready0", 32'(coin0_ready), 32'd0);
        check("rst_vend", 32'(vend), 32'd0);
        check("rst_change", 32'(change_pulse), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_sold_out", 32'(sold_out), 32'd0);
        check("rst_credit", 32'(credit), 32'd0);
        check("rst_stock", 32'(stock), 32'd8);
        coin0_valid = 1'b0;
        step();
        step();
        rst = 1'b0;

        // Reset in the middle of collecting.
        send(0, 2'b10);
        check("mid_credit", 32'(credit), 32'd10);
        rst = 1'b1;
        #1;
        check("mid_rst_credit", 32'(credit), 32'd0);
        check("mid_rst_stock", 32'(stock), 32'd8);
        check("mid_rst_vend", 32'(vend), 32'd0);
        check("mid_rst_change", 32'(change_pulse), 32'd0);
        coin0_valid = 1'b1; coin0_val = 2'b01;
        #1;
        check("mid_rst_ready0", 32'(coin0_ready), 32'd0);
        coin0_valid = 1'b0;
        rst = 1'b0;

        // Exact pay: 5 + 5 + 5.
        send(0, 2'b01);
        check("exact_c5", 32'(credit), 32'd5);
        send(0, 2'b01);
        check("exact_c10", 32'(credit), 32'd10);
        send(0, 2'b01);
        check("exact_vend", 32'(vend), 32'd1);
        check("exact_c15", 32'(credit), 32'd15);
        check("exact_busy", 32'(busy), 32'd1);
        step();
        check("exact_vend_off", 32'(vend), 32'd0);
        check("exact_c0", 32'(credit), 32'd0);
        check("exact_nochg", 32'(change_pulse), 32'd0);
        check("exact_stock", 32'(stock), 32'd7);
        step();
        check("exact_nochg2", 32'(change_pulse), 32'd0);

        // Overpay: 10 + 10 leaves one unit of change.
        send(0, 2'b10);
        check("over_c10", 32'(credit), 32'd10);
        send(1, 2'b10);
        check("over_vend", 32'(vend), 32'd1);
        check("over_c20", 32'(credit), 32'd20);
        step();
        check("over_vend_off", 32'(vend), 32'd0);
        check("over_chg1", 32'(change_pulse), 32'd1);
        check("over_c5", 32'(credit), 32'd5);
        check("over_stock", 32'(stock), 32'd6);
        step();
        check("over_chg_off", 32'(change_pulse), 32'd0);
        check("over_c0", 32'(credit), 32'd0);
        check("over_idle", 32'(busy), 32'd0);

        // Fairness: both ports hold 5-unit coins.
        coin0_valid = 1'b1; coin0_val = 2'b01;
        coin1_valid = 1'b1; coin1_val = 2'b01;
        #1;
        check("fair_g0_r0", 32'(coin0_ready), 32'd1);
        check("fair_g0_r1", 32'(coin1_ready), 32'd0);
        step();
        check("fair_c5", 32'(credit), 32'd5);
        check("fair_g1_r0", 32'(coin0_ready), 32'd0);
        check("fair_g1_r1", 32'(coin1_ready), 32'd1);
        step();
        check("fair_c10", 32'(credit), 32'd10);
        check("fair_g2_r0", 32'(coin0_ready), 32'd1);
        check("fair_g2_r1", 32'(coin1_ready), 32'd0);
        step();
        check("fair_vend", 32'(vend), 32'd1);
        check("fair_c15", 32'(credit), 32'd15);
        check("fair_vend_r", 32'({coin1_ready, coin0_ready}), 32'd0);
        coin0_valid = 1'b0;
        coin1_valid = 1'b0;
        step();
        check("fair_stock", 32'(stock), 32'd5);
        check("fair_c0", 32'(credit), 32'd0);

        // Refund, with cancel beating a simultaneous coin.
        send(0, 2'b10);
        check("ref_c10", 32'(credit), 32'd10);
        cancel = 1'b1;
        coin0_valid = 1'b1; coin0_val = 2'b01;
        #1;
        check("ref_conflict_r0", 32'(coin0_ready), 32'd0);
        step();
        cancel = 1'b0;
        coin0_valid = 1'b0;
        check("ref_chg1", 32'(change_pulse), 32'd1);
        check("ref_c10_hold", 32'(credit), 32'd10);
        check("ref_busy", 32'(busy), 32'd1);
        check("ref_novend1", 32'(vend), 32'd0);
        step();
        check("ref_chg2", 32'(change_pulse), 32'd1);
        check("ref_c5", 32'(credit), 32'd5);
        check("ref_novend2", 32'(vend), 32'd0);
        step();
        check("ref_chg_off", 32'(change_pulse), 32'd0);
        check("ref_c0", 32'(credit), 32'd0);
        check("ref_idle", 32'(busy), 32'd0);
        check("ref_stock", 32'(stock), 32'd5);

        // Drain the remaining stock.
        for (int i = 0; i < 5; i++) begin
            send(0, 2'b10);
            send(0, 2'b01);
            check("drain_vend", 32'(vend), 32'd1);
            step();
            check("drain_stock", 32'(stock), 32'(4 - i));
        end
        check("so_flag", 32'(sold_out), 32'd1);
        coin0_valid = 1'b1; coin0_val = 2'b01;
        coin1_valid = 1'b1; coin1_val = 2'b01;
        #1;
        check("so_ready", 32'({coin1_ready, coin0_ready}), 32'd0);
        step();
        check("so_credit", 32'(credit), 32'd0);
        restock = 1'b1;
        coin0_valid = 1'b0;
        coin1_valid = 1'b0;
        #1;
        check("so_before_edge", 32'(sold_out), 32'd1);
        step();
        restock = 1'b0;
        check("restock_stock", 32'(stock), 32'd8);
        check("restock_so", 32'(sold_out), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/vend_ctrl.md
Name: vend_ctrl

Overview:
- Transaction controller for the coin-operated vending path.
- Arbitrates two coin sources into one credit accumulator: front coin slot (port 0) and auxiliary acceptor (port 1).
- Triggers product dispense when credit reaches price and sequences change or refund as unit pulses.
- Tracks product stock.
- Sits between the coin acceptors and the dispense/change actuators.

Parameters:
- PRICE, 15, item price in currency units; must be a multiple of 5.
- CREDIT_W, 5, credit register width; must hold PRICE+5.
- STOCK_INIT, 8, stock loaded at reset and on restock.
- STOCK_W, 4, stock counter width; must hold STOCK_INIT.
- TIMEOUT_CYC, 1000, collect inactivity limit; used only with VEND_TIMEOUT_EN.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- coin0_valid  in  1  port 0 coin presented.
- coin0_val  in  2  port 0 coin code.
- coin0_ready  out  1  port 0 coin accepted this cycle.
- coin1_valid  in  1  port 1 coin presented.
- coin1_val  in  2  port 1 coin code.
- coin1_ready  out  1  port 1 coin accepted this cycle.
- cancel  in  1  user refund request, level-sampled.
- restock  in  1  reload stock, level-sampled.
- vend  out  1  one-cycle dispense pulse.
- change_pulse  out  1  one pulse per 5 units returned.
- busy  out  1  high in VEND, CHANGE and REFUND.
- sold_out  out  1  stock == 0.
- credit  out  CREDIT_W  current credit.
- stock  out  STOCK_W  current stock.

Behaviour:
- Single clock domain.
- Reset (async, active-high) clears all state: state=IDLE, credit=0, stock=STOCK_INIT, rr pointer=port 0. Outputs at reset: vend=0, change_pulse=0, busy=0, sold_out=0 (STOCK_INIT>0), ready outputs=0.
- Reset mid-transaction discards credit silently; no refund pulses are issued.
- Coin codes: 01=5 units, 10=10 units. Codes 00 and 11 are accepted (handshake completes) but add 0 credit.
- Handshake: a transfer occurs when valid && ready. Source holds valid and val stable until ready. ready is combinational.
- ready is asserted only when all of: state is IDLE or COLLECT, sold_out=0, cancel=0. At most one port is ready per cycle.
- Arbitration: round-robin. If both ports are valid, grant goes to the port not granted last; the pointer updates on each transfer. A lone valid port is always granted.
- Credit update: credit_next = credit + coin value, registered on the transfer edge.
- States:
  - IDLE: credit=0. A transfer goes to COLLECT, or directly to VEND if value >= PRICE. restock=1 reloads stock=STOCK_INIT; restock is ignored in all other states.
  - COLLECT: a transfer making credit >= PRICE goes to VEND. cancel=1 goes to REFUND (credit>0 is guaranteed here).
  - VEND: vend=1 for exactly one cycle; stock -= 1; credit -= PRICE. Next state is CHANGE if the remainder is >0, otherwise IDLE.
  - CHANGE / REFUND: change_pulse=1 every cycle; credit -= 5 per cycle; go to IDLE on the cycle credit reaches 0.
- Latency: vend asserts the cycle after the qualifying transfer. The first change pulse follows vend on the next cycle. A refund's first pulse comes the cycle after cancel is sampled.
- Max credit is PRICE+5 (PRICE-5 held plus a 10-unit coin); no overflow is possible.
- cancel is ignored in IDLE, VEND, CHANGE and REFUND.
- cancel and a valid coin in the same cycle: cancel wins; the coin is not accepted.
- sold_out deasserts the cycle after restock.

Optional Feature:
- Macro: VEND_TIMEOUT_EN.
- With it defined: a counter runs in COLLECT and clears on every transfer. Reaching TIMEOUT_CYC-1 forces REFUND, exactly as cancel would. The counter is held at 0 outside COLLECT.
- Without it: no counter logic is present, and credit is held in COLLECT indefinitely.

Decomposition:
- Package vend_pkg:
  - state enum (IDLE, COLLECT, VEND, CHANGE, REFUND)
  - coin codes COIN_NONE=2'b00, COIN_5=2'b01, COIN_10=2'b10
  - COIN_UNIT=5
  - coin-to-value function
- Sub-module rr_arb2: two-requester round-robin arbiter. Inputs: req[1:0], gate. Outputs: gnt[1:0], registered last-grant pointer. The pointer advances on an accept strobe.

Test Plan:
- Reset: assert rst mid-COLLECT with credit=10 -> credit=0, stock=8, vend=0, change_pulse=0, ready low while rst is high.
- Exact pay: port 0 sends 01, 01, 01 -> credit 5, 10, then VEND; one vend pulse; credit 0; no change_pulse; stock 7.
- Overpay: port 0 sends 10, then port 1 sends 10 -> vend pulse, then exactly one change_pulse, then IDLE; stock decrements by 1.
- Fairness: both ports hold valid with code 01 -> grants alternate 0, 1, 0; vend after the third grant.
- Refund and conflict: send code 10, then cancel with coin0_valid=1 in the same cycle -> coin0_ready=0; two change_pulses; vend never asserted.
- Sold out: perform 8 vends -> sold_out=1 and both ready=0 while valid; restock in IDLE -> sold_out=0 and stock=8 the next cycle.
